// File: rtl/vpe_accum_if.sv
// Psum-stream, adder-control and result-stream bundle for the VPE accumulation sequencer.
interface vpe_accum_if #(
  parameter int unsigned PSUM_WIDTH = 32,
  parameter int unsigned DEPTH      = 16
);
  localparam int unsigned RowW = $clog2(DEPTH);

  logic                  in_valid;
  logic                  in_ready;
  logic                  adder_enable;
  logic                  adder_sel_psum_bias;
  logic [PSUM_WIDTH-1:0] selected_psum;
  logic [RowW-1:0]       bias_addr;
  logic [PSUM_WIDTH-1:0] adder_out;
  logic                  out_valid;
  logic [PSUM_WIDTH-1:0] out_data;
  logic [RowW-1:0]       out_row;
  logic                  out_ready;

  modport master (
    input  in_valid,
    output in_ready,
    output adder_enable,
    output adder_sel_psum_bias,
    output selected_psum,
    output bias_addr,
    input  adder_out,
    output out_valid,
    output out_data,
    output out_row,
    input  out_ready
  );

  modport slave (
    output in_valid,
    input  in_ready,
    input  adder_enable,
    input  adder_sel_psum_bias,
    input  selected_psum,
    input  bias_addr,
    output adder_out,
    input  out_valid,
    input  out_data,
    input  out_row,
    output out_ready
  );
endinterface

// File: rtl/vpe_accum_ctrl.sv
// Tile/row sequencer for the VPE adder: keeps partial sums between tiles, emits final sums.
// Optional stall counter output enabled by defining VPE_ACCUM_PERF_EN.
module vpe_accum_ctrl #(
  parameter int unsigned PSUM_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned TILE_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [$clog2(DEPTH):0] cfg_num_rows,
  input  logic [TILE_W-1:0]      cfg_num_tiles,
  input  logic                   cfg_bias_en,
  vpe_accum_if.master            bus,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err
`ifdef VPE_ACCUM_PERF_EN
  ,
  output logic [31:0]            stall_cycles
`endif
);

  localparam int unsigned RowW = $clog2(DEPTH);
  localparam logic [RowW:0] DepthCnt = (RowW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StAccum, StDrain} state_e;

  state_e                state_q, state_d;
  logic [RowW-1:0]       row_q, row_d;
  logic [TILE_W-1:0]     tile_q, tile_d;
  logic [RowW:0]         num_rows_q, num_rows_d;
  logic [TILE_W-1:0]     num_tiles_q, num_tiles_d;
  logic                  bias_en_q, bias_en_d;
  logic                  out_valid_q, out_valid_d;
  logic [PSUM_WIDTH-1:0] out_data_q, out_data_d;
  logic [RowW-1:0]       out_row_q, out_row_d;
  logic                  done_q, done_d;
  logic                  cfg_err_q, cfg_err_d;

  logic [PSUM_WIDTH-1:0] psum_buf [DEPTH];

  logic cfg_ok, in_accum, last_tile, last_row, out_free, in_ready, accept;

  assign cfg_ok    = (cfg_num_rows != '0) && (cfg_num_rows <= DepthCnt) && (cfg_num_tiles != '0);
  assign in_accum  = (state_q == StAccum);
  assign last_tile = (tile_q == num_tiles_q - TILE_W'(1));
  assign last_row  = ({1'b0, row_q} == num_rows_q - (RowW + 1)'(1));
  // The output register can take a new beat if it is empty or being drained this cycle.
  assign out_free  = !out_valid_q || bus.out_ready;
  assign in_ready  = in_accum && (!last_tile || out_free);
  assign accept    = bus.in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    tile_d      = tile_q;
    num_rows_d  = num_rows_q;
    num_tiles_d = num_tiles_q;
    bias_en_d   = bias_en_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;

    if (accept && last_tile) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.adder_out;
      out_row_d   = row_q;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (cfg_ok) begin
            num_rows_d  = cfg_num_rows;
            num_tiles_d = cfg_num_tiles;
            bias_en_d   = cfg_bias_en;
            row_d       = '0;
            tile_d      = '0;
            state_d     = StAccum;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      StAccum: begin
        if (accept) begin
          if (last_row) begin
            row_d = '0;
            if (last_tile) begin
              state_d = StDrain;
            end else begin
              tile_d = tile_q + TILE_W'(1);
            end
          end else begin
            row_d = row_q + RowW'(1);
          end
        end
      end
      StDrain: begin
        if (out_free) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      row_q       <= '0;
      tile_q      <= '0;
      num_rows_q  <= '0;
      num_tiles_q <= '0;
      bias_en_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      tile_q      <= tile_d;
      num_rows_q  <= num_rows_d;
      num_tiles_q <= num_tiles_d;
      bias_en_q   <= bias_en_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Final tile goes to the output register only; earlier tiles update the partial sum.
  always_ff @(posedge clk) begin
    if (accept && !last_tile) begin
      psum_buf[row_q] <= bus.adder_out;
    end
  end

  assign bus.in_ready            = in_ready;
  assign bus.bias_addr           = in_accum ? row_q : '0;
  assign bus.selected_psum       = in_accum ? psum_buf[row_q] : '0;
  assign bus.adder_sel_psum_bias = in_accum && (tile_q == '0);
  assign bus.adder_enable        = in_accum && ((tile_q != '0) || bias_en_q);
  assign bus.out_valid           = out_valid_q;
  assign bus.out_data            = out_data_q;
  assign bus.out_row             = out_row_q;
  assign busy                    = (state_q != StIdle);
  assign done                    = done_q;
  assign cfg_err                 = cfg_err_q;

`ifdef VPE_ACCUM_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if ((state_q == StIdle) && start && cfg_ok) begin
      stall_q <= '0;
    end else if (in_accum && bus.in_valid && !in_ready) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_vpe_accum_ctrl.sv
// Directed bench for vpe_accum_ctrl: bench-side adder, sum-of-tiles model and literal checks.
module tb_vpe_accum_ctrl;
  localparam int unsigned W  = 32;
  localparam int unsigned D  = 16;
  localparam int unsigned TW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [4:0]    cfg_num_rows = '0;
  logic [TW-1:0] cfg_num_tiles = '0;
  logic          cfg_bias_en = 1'b0;
  logic          busy, done, cfg_err;
`ifdef VPE_ACCUM_PERF_EN
  logic [31:0]   stall_cycles;
`endif

  always #5 clk = ~clk;

  vpe_accum_if #(.PSUM_WIDTH(W), .DEPTH(D)) bus ();

  vpe_accum_ctrl #(.PSUM_WIDTH(W), .DEPTH(D), .TILE_W(TW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_num_rows (cfg_num_rows),
    .cfg_num_tiles(cfg_num_tiles),
    .cfg_bias_en  (cfg_bias_en),
    .bus          (bus.master),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err)
`ifdef VPE_ACCUM_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  logic [31:0] beat_data;
  logic [31:0] bias_tab [D];
  logic [31:0] beats [8][D];

  // Stand-in for the VPE adder, driven purely by the controller's select/enable outputs.
  always_comb begin
    bus.adder_out = beat_data;
    if (bus.adder_enable) begin
      bus.adder_out = beat_data + (bus.adder_sel_psum_bias ? bias_tab[bus.bias_addr]
                                                            : bus.selected_psum);
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Job model: final sum of row r is bias (if enabled) plus every tile's beat for that row.
  int          m_r = 1;
  int          m_k = 1;
  bit          m_bias = 1'b0;
  int          beat_idx = 0;
  logic [31:0] exp_data_q [$];
  int          exp_row_q [$];
  logic [31:0] got_q [$];
  int          cyc = 0;
  int          valid_cycles = 0;
  int          last_valid_cyc = 0;
  int          done_cyc = 0;

  function automatic logic [31:0] partial(input int r, input int upto);
    logic [31:0] s = m_bias ? bias_tab[r] : 32'd0;
    for (int t = 0; t < upto; t++) s = s + beats[t][r];
    return s;
  endfunction

  task automatic set_cfg(input int r, input int k, input bit b);
    m_r = r;
    m_k = k;
    m_bias = b;
    cfg_num_rows = 5'(r);
    cfg_num_tiles = TW'(k);
    cfg_bias_en = b;
    beat_idx = 0;
    exp_data_q.delete();
    exp_row_q.delete();
    got_q.delete();
    valid_cycles = 0;
    for (int i = 0; i < r; i++) begin
      exp_data_q.push_back(partial(i, k));
      exp_row_q.push_back(i);
    end
  endtask

  logic        prev_hold = 1'b0;
  logic [31:0] hold_data;
  logic [3:0]  hold_row;
  int          ct, cr;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      prev_hold <= 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        ct = beat_idx / m_r;
        cr = beat_idx % m_r;
        check("bias_addr", 32'(bus.bias_addr), cr);
        check("adder_sel", 32'(bus.adder_sel_psum_bias), 32'(ct == 0));
        check("adder_enable", 32'(bus.adder_enable), 32'((ct != 0) || m_bias));
        if (ct > 0) check("selected_psum", bus.selected_psum, partial(cr, ct));
        beat_idx++;
      end
      if (prev_hold) begin
        check("held_out_data", bus.out_data, hold_data);
        check("held_out_row", 32'(bus.out_row), 32'(hold_row));
      end
      if (bus.out_valid) begin
        valid_cycles++;
        last_valid_cyc = cyc;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_data_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL out_extra: got 0x%0h, expected no output", bus.out_data);
        end else begin
          check("out_data", bus.out_data, exp_data_q.pop_front());
          check("out_row", 32'(bus.out_row), exp_row_q.pop_front());
          got_q.push_back(bus.out_data);
        end
      end
      if (done) done_cyc = cyc;
      prev_hold <= bus.out_valid && !bus.out_ready;
      hold_data <= bus.out_data;
      hold_row  <= bus.out_row;
    end
  end

  // All tasks below start and end at #1 after a rising edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_beats(input int s, input int n);
    bit acc;
    int guard;
    for (int i = s; i < s + n; i++) begin
      beat_data = beats[i / m_r][i % m_r];
      bus.in_valid = 1'b1;
      guard = 0;
      acc = 1'b0;
      while (!acc && guard < 200) begin
        @(negedge clk);
        acc = bus.in_ready;
        @(posedge clk); #1;
        guard++;
      end
      if (!acc) begin
        timeout_fail("beat_accept");
        bus.in_valid = 1'b0;
        return;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        check("busy_at_done", 32'(busy), 0);
      end
    end
    @(posedge clk); #1;
    if (!seen) timeout_fail("done_pulse");
    check("outputs_pending", exp_data_q.size(), 0);
  endtask

  task automatic stall_hold(input int n);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.out_valid && k < 200);
    if (!bus.out_valid) timeout_fail("stall_wait_valid");
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_in_ready", 32'(bus.in_ready), 0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    beat_data = '0;
    for (int i = 0; i < int'(D); i++) bias_tab[i] = 32'(100 * i);
    for (int t = 0; t < 8; t++)
      for (int r = 0; r < int'(D); r++) beats[t][r] = '0;

    #1;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_row", 32'(bus.out_row), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cfg_err", 32'(cfg_err), 0);
    check("rst_in_ready", 32'(bus.in_ready), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // R=4 K=3 with bias; beat = tile + row.
    for (int t = 0; t < 3; t++)
      for (int r = 0; r < 4; r++) beats[t][r] = 32'(t + r);
    set_cfg(4, 3, 1'b1);
    pulse_start();
    check("busy_after_start", 32'(busy), 1);
    drive_beats(0, 12);
    wait_done();
    check("t1_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      check("t1_row0", got_q[0], 32'd3);
      check("t1_row1", got_q[1], 32'd106);
      check("t1_row2", got_q[2], 32'd209);
      check("t1_row3", got_q[3], 32'd312);
    end
    check("t1_valid_cycles", valid_cycles, 4);
    check("t1_done_timing", done_cyc, last_valid_cyc + 1);

    // R=2 K=1 pass-through.
    beats[0][0] = 32'd5;
    beats[0][1] = -32'sd7;
    set_cfg(2, 1, 1'b0);
    pulse_start();
    drive_beats(0, 2);
    wait_done();
    check("t2_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("t2_out0", got_q[0], 32'd5);
      check("t2_out1", got_q[1], 32'hFFFF_FFF9);
    end

    // R=3 K=2, downstream stalls for 5 cycles once final sums appear.
    for (int t = 0; t < 2; t++)
      for (int r = 0; r < 3; r++) beats[t][r] = 32'(t * 10 + r + 1);
    set_cfg(3, 2, 1'b1);
    bus.out_ready = 1'b0;
    pulse_start();
    fork
      drive_beats(0, 6);
      stall_hold(5);
    join
    wait_done();
    check("t3_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("t3_out0", got_q[0], 32'd12);
      check("t3_out1", got_q[1], 32'd114);
      check("t3_out2", got_q[2], 32'd216);
    end

    // Illegal configurations.
    cfg_num_rows = 5'd0;
    cfg_num_tiles = 8'd1;
    pulse_start();
    check("cfg_err_rows0", 32'(cfg_err), 1);
    check("busy_rows0", 32'(busy), 0);
    @(posedge clk); #1;
    check("cfg_err_pulse", 32'(cfg_err), 0);
    cfg_num_rows = 5'd2;
    cfg_num_tiles = 8'd0;
    pulse_start();
    check("cfg_err_tiles0", 32'(cfg_err), 1);
    check("busy_tiles0", 32'(busy), 0);
    cfg_num_rows = 5'd17;
    cfg_num_tiles = 8'd1;
    pulse_start();
    check("cfg_err_rows17", 32'(cfg_err), 1);
    check("busy_rows17", 32'(busy), 0);
    cfg_num_rows = 5'd16;
    pulse_start();
    check("cfg_err_rows16", 32'(cfg_err), 0);
    check("busy_rows16", 32'(busy), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Start during ACCUM is ignored.
    beats[0][0] = 32'd21;
    beats[0][1] = 32'd22;
    set_cfg(2, 1, 1'b0);
    pulse_start();
    drive_beats(0, 1);
    cfg_num_rows = 5'd5;
    cfg_num_tiles = 8'd3;
    cfg_bias_en = 1'b1;
    pulse_start();
    check("cfg_err_busy_start", 32'(cfg_err), 0);
    drive_beats(1, 1);
    wait_done();
    check("t4_count", got_q.size(), 2);

    // Reset mid tile 1, then rerun.
    for (int t = 0; t < 2; t++)
      for (int r = 0; r < 4; r++) beats[t][r] = 32'(t * 4 + r + 1);
    set_cfg(4, 2, 1'b1);
    pulse_start();
    drive_beats(0, 6);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_in_ready", 32'(bus.in_ready), 0);
    check("midrst_out_data", bus.out_data, 0);
    repeat (2) @(posedge clk);
    check("midrst_done", 32'(done), 0);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_done", 32'(done), 0);
    set_cfg(4, 2, 1'b1);
    pulse_start();
    drive_beats(0, 8);
    wait_done();
    check("t5_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      check("t5_out0", got_q[0], 32'd6);
      check("t5_out3", got_q[3], 32'd312);
    end

`ifdef VPE_ACCUM_PERF_EN
    beats[0][0] = 32'd1;
    beats[0][1] = 32'd2;
    set_cfg(2, 1, 1'b0);
    bus.out_ready = 1'b0;
    pulse_start();
    check("stall_clear_start", stall_cycles, 0);
    fork
      drive_beats(0, 2);
      stall_hold(3);
    join
    wait_done();
    check("stall_cycles_3", stall_cycles, 3);
    repeat (2) @(posedge clk); #1;
    check("stall_hold_idle", stall_cycles, 3);
    set_cfg(2, 1, 1'b0);
    pulse_start();
    check("stall_cleared", stall_cycles, 0);
    drive_beats(0, 2);
    wait_done();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vpe_accum_ctrl.md
Name: vpe_accum_ctrl

Overview:
- Sequencer for the VPE adder.
- Walks K tiles of R rows of psum beats. Tile 0 adds bias (or passes through); tiles 1..K-1 add the stored psum.
- Holds the per-row psum buffer between tiles and emits final sums on a registered valid/ready output.
- Sits between the systolic-array psum stream and the downstream VPE stages.

Parameters:
- PSUM_WIDTH, 32, width of psum, bias and result.
- DEPTH, 16, psum buffer entries; maximum rows per tile.
- TILE_W, 8, width of the tile-count config.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  pulse; latches config when IDLE
- cfg_num_rows  in  $clog2(DEPTH)+1  rows per tile R, legal 1..DEPTH
- cfg_num_tiles  in  TILE_W  tiles K, legal >=1
- cfg_bias_en  in  1  1: tile 0 adds bias; 0: tile 0 passes through
- in_valid  in  1  psum beat valid from array
- in_ready  out  1  beat accepted when in_valid&&in_ready
- adder_enable  out  1  drives the adder enable
- adder_sel_psum_bias  out  1  0: psum, 1: bias
- selected_psum  out  PSUM_WIDTH  psum buffer read data for the current row
- bias_addr  out  $clog2(DEPTH)  row index for the external bias table
- adder_out  in  PSUM_WIDTH  adder result, same cycle as beat
- out_valid  out  1  final sum valid
- out_data  out  PSUM_WIDTH  final sum
- out_row  out  $clog2(DEPTH)  row of out_data
- out_ready  in  1  downstream accept
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at job end
- cfg_err  out  1  one-cycle pulse on illegal start

Behaviour:
- Reset (rst=0, async): state=IDLE; counters=0; out_valid=0; out_data=0; out_row=0; done=0; cfg_err=0. Buffer contents undefined.
- States: IDLE, ACCUM, DRAIN.
- IDLE + start:
  - cfg_num_rows==0, cfg_num_rows>DEPTH or cfg_num_tiles==0: cfg_err pulse next cycle, stay IDLE.
  - Otherwise: latch R, K, bias_en; row=0, tile=0; go ACCUM.
  - start outside IDLE is ignored.
- ACCUM, in_ready:
  - Tiles < K-1: in_ready=1.
  - Last tile: in_ready = !out_valid || out_ready.
  - IDLE/DRAIN: in_ready=0.
- Combinational adder controls, driven every ACCUM cycle:
  - bias_addr = row.
  - selected_psum = buf[row] (asynchronous read).
  - adder_sel_psum_bias = (tile==0).
  - adder_enable = (tile!=0) || bias_en.
  - In IDLE/DRAIN all control outputs are 0.
- Accepted beat:
  - tile<K-1: buf[row] <= adder_out.
  - tile==K-1: out_data <= adder_out, out_row <= row, out_valid <= 1. No buffer write.
  - Row counter: row==R-1 wraps to 0 and tile++; otherwise row++.
  - Last row of last tile: go DRAIN.
- K==1: every beat goes straight to the output; the buffer is never written.
- Output register: out_valid clears on out_ready unless a new beat loads the same cycle; then it stays 1 with the new data. Latency is 1 cycle from the accepted last-tile beat to out_valid. Full throughput when out_ready=1.
- DRAIN: wait for !out_valid || out_ready. Then done pulses for 1 cycle and state goes to IDLE (busy=0 the same cycle done=1).
- in_valid while not in_ready: beat held upstream; counters unchanged.
- Arithmetic: the adder owns the add; the controller stores adder_out unmodified at PSUM_WIDTH. Wrap-around is the adder's behaviour.
- Reset mid-job: job aborted, out_valid=0, no done pulse.

Optional Feature:
- Macro: VPE_ACCUM_PERF_EN.
- Defined: adds output stall_cycles, 32 bits, wrapping. It counts ACCUM cycles with in_valid && !in_ready, clears on an accepted start, and holds its value in IDLE.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- R=4, K=3, bias_en=1, bias[r]=100*r, beats tile t row r = t+r, out_ready=1 -> out rows 0..3 = 3, 106, 209, 312; out_valid exactly 4 cycles; done one cycle after last out.
- R=2, K=1, bias_en=0, beats 5 and -7 -> adder_enable=0, out_data 5 then 0xFFFFFFF9; no buffer writes; done.
- R=3, K=2, out_ready=0 for 5 cycles during tile 1 -> in_ready=0 after first final beat, out_data held stable; releasing out_ready gives 3 outputs in order with no loss or duplication.
- start with cfg_num_rows=0, then cfg_num_tiles=0 -> cfg_err pulses twice, busy stays 0; start during ACCUM is ignored and config is unchanged.
- Assert rst mid-tile 1 of R=4, K=2, then rerun the job -> outputs 0 during reset; rerun results match a clean run (tile 0 overwrites the buffer).
- VPE_ACCUM_PERF_EN: 3 stalled cycles with in_valid=1 -> stall_cycles=3; next start clears it to 0.
